ps2_host_cmd: RTL and testbench
===============================

// Module: ps2_host_cmd
// PURPOSE
//  Host-to-keyboard command sequencer for the PS/2 port shared with the keyboard receiver.
//  Sends a command byte (e.g. 0xED set-LEDs, 0xFF reset) and an optional argument byte.
//  Performs the PS/2 host-request protocol with open-drain line control.
//  Collects the device response and reports done/error.
//  Asserts oRxInhibit so the keyboard receiver ignores traffic while a transaction is open.
// PARAMETERS
//  INHIBIT_CYC  5000     CLK cycles PS2_CLK is held low before request (100 us @ 50 MHz)
//  TIMEOUT_CYC  1000000  max CLK cycles between PS2_CLK falling edges once request issued
//  MAX_RETRY    2        retransmissions allowed on 0xFE (resend) response
// PORTS
//  CLK         in   1  system clock
//  reset       in   1  asynchronous, active-high reset
//  PS2_CLK     in   1  sampled PS/2 clock line
//  PS2_DATA    in   1  sampled PS/2 data line
//  iCmdValid   in   1  command request, accepted when oCmdReady=1
//  iCmd        in   8  command byte
//  iHasArg     in   1  1: iArg follows after command ACK
//  iArg        in   8  argument byte
//  oCmdReady   out  1  1 in IDLE only
//  oClkLow     out  1  1: pull PS2_CLK low (open-drain enable)
//  oDataLow    out  1  1: pull PS2_DATA low (open-drain enable)
//  oRxInhibit  out  1  1 whenever state != IDLE
//  oDone       out  1  one-cycle pulse: transaction completed with 0xFA on every byte
//  oErr        out  1  one-cycle pulse: transaction aborted
//  oErrCode    out  2  0 none, 1 timeout, 2 no line-ACK, 3 bad response/framing/retries; held until next accept
// BEHAVIOUR
//  - Reset (async): state=IDLE, all outputs 0 except oCmdReady=1; lines released immediately.
//  - PS2_CLK/PS2_DATA pass through 2-flop synchronisers. Falling edge fe = prev 1, cur 0 (2-3 cycle lag).
//  - Accept: iCmdValid & oCmdReady latches iCmd/iHasArg/iArg, clears retry count and oErrCode.
//    Next cycle enters INHIBIT.
//  - INHIBIT: oClkLow=1, oDataLow=0 for exactly INHIBIT_CYC cycles.
//    Then REQ: oDataLow=1 (start bit), oClkLow=0 from the same cycle on.
//  - TX: on each fe, bit count n=1..11:
//      n=1..8   drive data bit n-1, LSB first (oDataLow = ~bit)
//      n=9      drive odd parity
//      n=10     release data (stop bit)
//      n=11     sample PS2_DATA; 0 = line-ACK -> RX, 1 -> error code 2
//  - RX: shift 11 bits on fe, data sampled at the fe.
//    Frame check: start=0, stop=1, odd parity over 8 data bits; failure -> error code 3.
//  - CHECK on a valid response byte:
//      0xFA, arg pending               -> load iArg into TX byte, clear retries, go to INHIBIT
//      0xFA, no arg pending            -> oDone pulse, IDLE
//      0xFE, retries < MAX_RETRY       -> retries+1, resend the same byte via INHIBIT
//      0xFE with retries exhausted, or any other byte -> error code 3
//  - Timeout: counter cleared on entry to REQ and on every fe.
//    Reaching TIMEOUT_CYC in REQ/TX/RX -> error code 1.
//  - Any error: oErr pulse, lines released that cycle, return to IDLE.
//  - While busy: iCmdValid is ignored (not queued).
//  - Device-initiated frames arriving in IDLE are ignored by this block.
// TESTING
//  1. Device model ACKs, returns 0xFA; cmd 0xF4, no arg.
//     -> TX bits 0,0,1,0,1,1,1,1, parity 0; oDone 1 pulse; oErrCode 0.
//  2. Cmd 0xED, arg 0x07; model returns 0xFA twice.
//     -> two INHIBIT phases; arg frame parity 0; single oDone after second ACK.
//  3. Model answers 0xFE, then 0xFA.
//     -> byte resent once, oDone.
//     Model answers 0xFE three times -> oErr with code 3 after 3rd 0xFE.
//  4. Model never clocks after REQ -> oErr code 1 at TIMEOUT_CYC cycles.
//     Model leaves data high at bit 11 -> oErr code 2.
//  5. Assert reset mid-TX (bit 5) -> oClkLow=oDataLow=0 same cycle, oCmdReady=1.
//     New cmd 0xFF then completes normally.
//  6. iCmdValid pulsed with 0xEE during RX -> ignored; oRxInhibit=1 throughout.
//     oCmdReady=0 until IDLE.

Source files
------------

// File: rtl/ps2_host_cmd.sv
// PS/2 host command sequencer.
// Sends a command byte and an optional argument byte to the device using the
// host-request protocol (clock inhibit, start bit, device-clocked bits, line ACK),
// then collects the device response frame. 0xFE responses trigger a bounded resend.
// The keyboard receiver is told to ignore the port for as long as a transaction is open.
module ps2_host_cmd #(
    parameter int INHIBIT_CYC = 5000,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int MAX_RETRY   = 2
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    input  logic       iCmdValid,
    input  logic [7:0] iCmd,
    input  logic       iHasArg,
    input  logic [7:0] iArg,
    output logic       oCmdReady,
    output logic       oClkLow,
    output logic       oDataLow,
    output logic       oRxInhibit,
    output logic       oDone,
    output logic       oErr,
    output logic [1:0] oErrCode
);

    // state   | meaning
    // IDLE    | lines released, ready for a command
    // INHIBIT | PS2_CLK held low for INHIBIT_CYC cycles
    // REQ     | clock released, start bit driven, waiting for first device clock
    // TX      | shifting data/parity/stop out on device clocks, line ACK on the 11th
    // RX      | shifting in the 11-bit response frame
    // CHECK   | evaluating the response byte
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_REQ     = 3'd2;
    localparam logic [2:0] S_TX      = 3'd3;
    localparam logic [2:0] S_RX      = 3'd4;
    localparam logic [2:0] S_CHECK   = 3'd5;

    localparam int INH_W = $clog2(INHIBIT_CYC + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 2);

    logic [2:0]       r_state;
    logic             r_clk_s1, r_clk_s2, r_clk_prev;
    logic             r_dat_s1, r_dat_s2;
    logic [INH_W-1:0] r_inh_cnt;
    logic [TMO_W-1:0] r_to;
    logic [3:0]       r_bit_cnt;
    logic [7:0]       r_tx_byte;
    logic [7:0]       r_arg;
    logic             r_has_arg;
    logic [RTY_W-1:0] r_retry;
    logic             r_data_low;
    logic [10:0]      r_rx_sh;
    logic             r_done;
    logic             r_err;
    logic [1:0]       r_err_code;

    logic             w_fe;
    logic             w_to_hit;
    logic             w_frame_ok;
    logic [7:0]       w_rx_byte;

    assign w_fe       = r_clk_prev & ~r_clk_s2;
    assign w_to_hit   = (r_to == TMO_W'(TIMEOUT_CYC - 1));
    assign w_rx_byte  = r_rx_sh[8:1];
    assign w_frame_ok = ~r_rx_sh[0] & r_rx_sh[10] & (^r_rx_sh[9:1]);

    // Outputs decode from state so reset releases the lines without waiting for a clock.
    assign oCmdReady  = (r_state == S_IDLE);
    assign oRxInhibit = (r_state != S_IDLE);
    assign oClkLow    = (r_state == S_INHIBIT);
    assign oDataLow   = (r_state == S_REQ) | ((r_state == S_TX) & r_data_low);
    assign oDone      = r_done;
    assign oErr       = r_err;
    assign oErrCode   = r_err_code;

    // Two-flop synchronisers on both PS/2 lines plus the previous clock sample for edge detect.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= PS2_CLK;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= PS2_DATA;
            r_dat_s2   <= r_dat_s1;
        end
    end

    // Transaction sequencer: request, transmit, receive, response check, retry and abort.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_inh_cnt  <= '0;
            r_to       <= '0;
            r_bit_cnt  <= '0;
            r_tx_byte  <= '0;
            r_arg      <= '0;
            r_has_arg  <= 1'b0;
            r_retry    <= '0;
            r_data_low <= 1'b0;
            r_rx_sh    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (iCmdValid) begin
                        r_tx_byte  <= iCmd;
                        r_arg      <= iArg;
                        r_has_arg  <= iHasArg;
                        r_retry    <= '0;
                        r_err_code <= 2'd0;
                        r_inh_cnt  <= INH_W'(INHIBIT_CYC - 1);
                        r_state    <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (r_inh_cnt == '0) begin
                        r_to    <= '0;
                        r_state <= S_REQ;
                    end else begin
                        r_inh_cnt <= r_inh_cnt - INH_W'(1);
                    end
                end
                S_REQ: begin
                    if (w_fe) begin
                        r_data_low <= ~r_tx_byte[0];
                        r_bit_cnt  <= 4'd1;
                        r_to       <= '0;
                        r_state    <= S_TX;
                    end else if (w_to_hit) begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'd1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_to <= r_to + TMO_W'(1);
                    end
                end
                S_TX: begin
                    if (w_fe) begin
                        r_to      <= '0;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        case (r_bit_cnt)
                            // Odd parity bit is ~^byte, so the pull-low enable is ^byte.
                            4'd8:    r_data_low <= ^r_tx_byte;
                            4'd9:    r_data_low <= 1'b0;
                            4'd10: begin
                                if (!r_dat_s2) begin
                                    r_bit_cnt <= 4'd0;
                                    r_state   <= S_RX;
                                end else begin
                                    r_err      <= 1'b1;
                                    r_err_code <= 2'd2;
                                    r_state    <= S_IDLE;
                                end
                            end
                            default: r_data_low <= ~r_tx_byte[r_bit_cnt[2:0]];
                        endcase
                    end else if (w_to_hit) begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'd1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_to <= r_to + TMO_W'(1);
                    end
                end
                S_RX: begin
                    if (w_fe) begin
                        r_to    <= '0;
                        r_rx_sh <= {r_dat_s2, r_rx_sh[10:1]};
                        if (r_bit_cnt == 4'd10) begin
                            r_state <= S_CHECK;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end else if (w_to_hit) begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'd1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_to <= r_to + TMO_W'(1);
                    end
                end
                S_CHECK: begin
                    if (w_frame_ok && w_rx_byte == 8'hFA) begin
                        if (r_has_arg) begin
                            r_tx_byte <= r_arg;
                            r_has_arg <= 1'b0;
                            r_retry   <= '0;
                            r_inh_cnt <= INH_W'(INHIBIT_CYC - 1);
                            r_state   <= S_INHIBIT;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else if (w_frame_ok && w_rx_byte == 8'hFE &&
                                 r_retry < RTY_W'(MAX_RETRY)) begin
                        r_retry   <= r_retry + RTY_W'(1);
                        r_inh_cnt <= INH_W'(INHIBIT_CYC - 1);
                        r_state   <= S_INHIBIT;
                    end else begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'd3;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_cmd.sv
// Bench for ps2_host_cmd: a PS/2 device model on open-drain lines, a transaction-level
// model of the expected outcome, and a per-cycle monitor of the status outputs.
module tb_ps2_host_cmd;

    localparam int INH   = 20;
    localparam int TMO   = 300;
    localparam int RETRY = 2;
    localparam int HALF  = 8;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       w_ps2_clk, w_ps2_data;
    logic       iCmdValid = 1'b0;
    logic [7:0] iCmd = 8'h00;
    logic       iHasArg = 1'b0;
    logic [7:0] iArg = 8'h00;
    logic       oCmdReady, oClkLow, oDataLow, oRxInhibit, oDone, oErr;
    logic [1:0] oErrCode;

    assign w_ps2_clk  = dev_clk & ~oClkLow;
    assign w_ps2_data = dev_data & ~oDataLow;

    ps2_host_cmd #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .MAX_RETRY(RETRY)) dut (
        .CLK(CLK), .reset(reset), .PS2_CLK(w_ps2_clk), .PS2_DATA(w_ps2_data),
        .iCmdValid(iCmdValid), .iCmd(iCmd), .iHasArg(iHasArg), .iArg(iArg),
        .oCmdReady(oCmdReady), .oClkLow(oClkLow), .oDataLow(oDataLow),
        .oRxInhibit(oRxInhibit), .oDone(oDone), .oErr(oErr), .oErrCode(oErrCode)
    );

    always #5 CLK = ~CLK;

    int         n_cmp = 0, n_bad = 0;
    int         n_done = 0, n_err = 0, n_inh = 0;
    logic       exp_busy = 1'b0;
    logic [1:0] exp_code = 2'd0;
    logic       settle = 1'b1;
    logic       mon_en = 1'b0;
    logic [9:0] last_tx = '0;
    int         rq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic odd_par(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return (ones % 2 == 0);
    endfunction

    // Per-cycle monitor of the status outputs against the model's busy/code expectation.
    always @(posedge CLK) begin
        #2;
        if (oDone) n_done++;
        if (oErr) n_err++;
        if (mon_en && !settle) begin
            chk("mon_ready", oCmdReady, !exp_busy);
            chk("mon_rxinh", oRxInhibit, exp_busy);
            chk("mon_done", oDone, 1'b0);
            chk("mon_err", oErr, 1'b0);
            chk("mon_code", oErrCode, exp_code);
            if (!exp_busy) chk("mon_lines", {oClkLow, oDataLow}, 2'b00);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    task automatic dev_wait(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_cmd(input logic [7:0] c, input logic h, input logic [7:0] a);
        @(negedge CLK);
        iCmd = c; iHasArg = h; iArg = a; iCmdValid = 1'b1;
        exp_busy = 1'b1; exp_code = 2'd0;
        @(negedge CLK);
        iCmdValid = 1'b0;
    endtask

    task automatic expect_inhibit();
        int w = 0;
        int len = 0;
        while (!oClkLow && w < 12) begin @(negedge CLK); w++; end
        chk("inh_start", oClkLow, 1'b1);
        dev_clk = 1'b1; dev_data = 1'b1;
        while (oClkLow && len < INH + 20) begin
            chk("inh_data", oDataLow, 1'b0);
            len++;
            @(negedge CLK);
        end
        chk("inh_len", len, INH);
        chk("req_start", {oClkLow, oDataLow}, 2'b01);
        n_inh++;
    endtask

    // Device clocks a host frame in, sampling each bit before its rising edge.
    task automatic host_frame(input logic [7:0] exp_b, input logic ack);
        logic [9:0] got = '0;
        for (int k = 1; k <= 11; k++) begin
            dev_wait(HALF);
            dev_clk = 1'b0;
            if (k == 11 && !ack) return;
            dev_wait(HALF);
            if (k <= 10) got[k-1] = w_ps2_data;
            dev_clk = 1'b1;
            if (k == 10) begin
                chk("tx_data", got[7:0], exp_b);
                chk("tx_par", got[8], odd_par(exp_b));
                chk("tx_stop", got[9], 1'b1);
                last_tx = got;
                if (ack) dev_data = 1'b0;
            end
            if (k == 11) dev_data = 1'b1;
        end
    endtask

    // Device sends a response frame; returns right after the last falling edge.
    task automatic dev_send(input logic [7:0] b, input logic bad);
        logic [10:0] f;
        f = {1'b1, odd_par(b) ^ bad, b, 1'b0};
        for (int k = 0; k <= 10; k++) begin
            dev_data = f[k];
            dev_wait(HALF);
            dev_clk = 1'b0;
            if (k < 10) begin
                dev_wait(HALF);
                dev_clk = 1'b1;
            end
        end
    endtask

    task automatic expect_end(input logic done, input logic [1:0] code);
        int w = 0;
        while (!(oDone || oErr) && w < 12) begin @(negedge CLK); w++; end
        chk("end_done", oDone, done);
        chk("end_err", oErr, !done);
        chk("end_code", oErrCode, code);
        chk("end_lines", {oClkLow, oDataLow}, 2'b00);
        chk("end_ready", oCmdReady, 1'b1);
        dev_clk = 1'b1; dev_data = 1'b1;
        exp_busy = 1'b0; exp_code = code; settle = 1'b0;
    endtask

    // Transaction model: walks the scripted responses in rq and predicts phases and outcome.
    task automatic run_txn(input logic [7:0] cmd, input logic has, input logic [7:0] arg,
                           input logic poke);
        logic [7:0] cur = cmd;
        logic       pend = has;
        int         retries = 0;
        int         d0 = n_done, e0 = n_err, i0 = n_inh, phases = 0;
        logic       fin = 1'b0;
        logic       ok = 1'b0;
        logic [1:0] code = 2'd0;
        logic [7:0] b;
        logic       bad;
        send_cmd(cmd, has, arg);
        for (int i = 0; i < rq.size() && !fin; i++) begin
            expect_inhibit();
            phases++;
            host_frame(cur, 1'b1);
            bad = (rq[i] > 255);
            b = rq[i][7:0];
            if (bad) begin fin = 1'b1; code = 2'd3; end
            else if (b == 8'hFA) begin
                if (pend) begin cur = arg; pend = 1'b0; retries = 0; end
                else begin fin = 1'b1; ok = 1'b1; end
            end else if (b == 8'hFE && retries < RETRY) retries++;
            else begin fin = 1'b1; code = 2'd3; end
            if (poke) begin
                @(negedge CLK);
                iCmd = 8'hEE; iHasArg = 1'b0; iCmdValid = 1'b1;
                @(negedge CLK);
                iCmdValid = 1'b0;
            end
            if (fin) settle = 1'b1;
            dev_send(b, bad);
            if (fin) expect_end(ok, code);
        end
        chk("txn_finished", fin, 1'b1);
        chk("txn_phases", n_inh - i0, phases);
        chk("txn_ndone", n_done - d0, ok ? 1 : 0);
        chk("txn_nerr", n_err - e0, ok ? 0 : 1);
    endtask

    initial begin
        int r;
        reset = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_ready", oCmdReady, 1'b1);
        chk("rst_rxinh", oRxInhibit, 1'b0);
        chk("rst_lines", {oClkLow, oDataLow}, 2'b00);
        chk("rst_pulses", {oDone, oErr}, 2'b00);
        chk("rst_code", oErrCode, 2'd0);
        reset = 1'b0;
        settle = 1'b0; mon_en = 1'b1;
        dev_wait(3);

        // Plain command, acknowledged.
        rq.delete(); rq.push_back(32'h0FA);
        run_txn(8'hF4, 1'b0, 8'h00, 1'b0);
        chk("pin_F4_data", last_tx[7:0], 8'hF4);
        chk("pin_F4_par", last_tx[8], 1'b0);

        // Command with argument: two request phases, one done.
        rq.delete(); rq.push_back(32'h0FA); rq.push_back(32'h0FA);
        run_txn(8'hED, 1'b1, 8'h07, 1'b0);
        chk("pin_07_data", last_tx[7:0], 8'h07);
        chk("pin_07_par", last_tx[8], 1'b0);

        // Single resend then success.
        rq.delete(); rq.push_back(32'h0FE); rq.push_back(32'h0FA);
        run_txn(8'hF4, 1'b0, 8'h00, 1'b0);

        // Resends exhausted.
        rq.delete(); rq.push_back(32'h0FE); rq.push_back(32'h0FE); rq.push_back(32'h0FE);
        run_txn(8'hF4, 1'b0, 8'h00, 1'b0);
        chk("pin_resend_code", exp_code, 2'd3);

        // Unexpected byte, and a parity-corrupted 0xFA.
        rq.delete(); rq.push_back(32'h0AB);
        run_txn(8'hF2, 1'b0, 8'h00, 1'b0);
        rq.delete(); rq.push_back(32'h1FA);
        run_txn(8'hF4, 1'b0, 8'h00, 1'b0);

        // Device never clocks after the request.
        send_cmd(8'hF4, 1'b0, 8'h00);
        expect_inhibit();
        settle = 1'b1;
        r = 1;
        while (!oErr && r < TMO + 20) begin
            @(negedge CLK);
            if (!oErr) r++;
        end
        chk("tmo_cycles", r, TMO);
        expect_end(1'b0, 2'd1);

        // Device leaves data high at the ACK bit.
        send_cmd(8'hF4, 1'b0, 8'h00);
        expect_inhibit();
        settle = 1'b1;
        host_frame(8'hF4, 1'b0);
        expect_end(1'b0, 2'd2);

        // Reset while bit 5 is on the wire.
        send_cmd(8'hF4, 1'b0, 8'h00);
        expect_inhibit();
        for (int k = 1; k <= 6; k++) begin
            dev_wait(HALF); dev_clk = 1'b0;
            dev_wait(HALF);
            if (k < 6) dev_clk = 1'b1;
        end
        chk("tx_bit5", oDataLow, 1'b0);
        reset = 1'b1;
        exp_busy = 1'b0; exp_code = 2'd0;
        #1;
        chk("rst_mid_lines", {oClkLow, oDataLow}, 2'b00);
        chk("rst_mid_ready", oCmdReady, 1'b1);
        dev_clk = 1'b1; dev_data = 1'b1;
        dev_wait(2);
        reset = 1'b0;
        dev_wait(2);
        rq.delete(); rq.push_back(32'h0FA);
        run_txn(8'hFF, 1'b0, 8'h00, 1'b0);
        chk("pin_FF_par", last_tx[8], 1'b1);

        // Command request during receive is ignored.
        rq.delete(); rq.push_back(32'h0FA);
        run_txn(8'hF4, 1'b0, 8'h00, 1'b1);
        dev_wait(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
